// File: rtl/univ_shift_register.sv
// WIDTH-bit universal shift register with a self-timed N-shift sequencer (busy/done handshake).
// Define UNIV_SHIFT_REGISTER_ABORT_EN to add an abort input that cancels a running sequence.
module univ_shift_register #(
  parameter int              WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int              CW        = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             E,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] D,
  input  logic             sin,
  input  logic             start,
  input  logic [CW-1:0]    n,
`ifdef UNIV_SHIFT_REGISTER_ABORT_EN
  input  logic             abort,
`endif
  output logic [WIDTH-1:0] Q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [2:0]       lmode;
  logic [2:0]       op;
  logic [WIDTH-1:0] nxt_q;
  logic             nxt_sout;
  logic             abort_req;
  logic             seq_mode;
  logic [CW-1:0]    n_sat;

`ifdef UNIV_SHIFT_REGISTER_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Only shift/rotate modes launch a real sequence; hold/load/clear degenerate to n=0.
  assign seq_mode = (mode[2:1] == 2'b01) || (mode[2:1] == 2'b10) || (mode == 3'b111);
  assign n_sat    = (n > CW'(WIDTH)) ? CW'(WIDTH) : n;
  assign op       = (state == RUN) ? lmode : mode;

  always_comb begin
    nxt_q    = Q;
    nxt_sout = sout;
    case (op)
      3'b001: nxt_q = D;
      3'b010: begin nxt_q = {Q[WIDTH-2:0], sin};      nxt_sout = Q[WIDTH-1]; end
      3'b011: begin nxt_q = {sin, Q[WIDTH-1:1]};      nxt_sout = Q[0];       end
      3'b100: begin nxt_q = {Q[WIDTH-2:0], Q[WIDTH-1]}; nxt_sout = Q[WIDTH-1]; end
      3'b101: begin nxt_q = {Q[0], Q[WIDTH-1:1]};     nxt_sout = Q[0];       end
      3'b110: nxt_q = '0;
      3'b111: begin nxt_q = {Q[WIDTH-1], Q[WIDTH-1:1]}; nxt_sout = Q[0];     end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      count <= '0;
      lmode <= 3'b000;
      Q     <= RESET_VAL;
      sout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (seq_mode && n != '0) begin
              state <= RUN;
              busy  <= 1'b1;
              lmode <= mode;
              count <= n_sat;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end else if (E) begin
            Q    <= nxt_q;
            sout <= nxt_sout;
          end
        end
        RUN: begin
          if (abort_req) begin
            state <= IDLE;
            busy  <= 1'b0;
            count <= '0;
          end else begin
            Q     <= nxt_q;
            sout  <= nxt_sout;
            count <= count - CW'(1);
            if (count == CW'(1)) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        DONE: state <= IDLE;
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/univ_shift_register.md
Name: univ_shift_register

Overview:
- Parametrised successor to the team's 4-bit enable register, for the iterative divider datapath.
- Holds a WIDTH-bit value and supports load, logical/arithmetic shifts, rotates and synchronous clear under a mode select.
- Adds an auto-shift sequencer that performs N shifts on its own with a busy/done handshake, so the divider control FSM can request multi-bit normalisation in one command.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- RESET_VAL, 0, value Q takes on reset.
- CW, $clog2(WIDTH+1), width of the shift-count input (derived; do not override).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  one clock; reset is asynchronous and active-low.
- E  in  1  manual-operation enable.
- mode  in  3  operation select (see Behaviour).
- D  in  WIDTH  parallel load data.
- sin  in  1  serial input for shifts.
- start  in  1  one-cycle request to launch the auto-shift sequence.
- n  in  CW  number of shifts for the sequence.
- Q  out  WIDTH  register contents.
- sout  out  1  last bit shifted or rotated out.
- busy  out  1  sequence running.
- done  out  1  one-cycle pulse when the sequence completes.

Behaviour:
- Reset (reset=0, asynchronous): Q=RESET_VAL, sout=0, busy=0, done=0, FSM=IDLE, count=0. Reset mid-sequence aborts immediately, with no done pulse.
- Mode encoding:
  - 000 hold
  - 001 load D
  - 010 shift left: sin enters the LSB, MSB goes to sout
  - 011 shift right: sin enters the MSB, LSB goes to sout
  - 100 rotate left
  - 101 rotate right
  - 110 synchronous clear to 0
  - 111 arithmetic shift right: MSB is replicated, LSB goes to sout
- For rotates, sout takes the bit that wrapped around. sout changes only on a shift or rotate; otherwise it holds. Clear and load leave sout unchanged.
- Manual operation happens in IDLE only. With E=1, the mode operation is applied at the next rising edge (1-cycle latency). With E=0, Q holds.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN on start=1 when mode is a shift/rotate (010-101, 111):
  - mode is latched at start; the start edge applies no manual operation.
  - count = min(n, WIDTH).
  - If n=0, go IDLE -> DONE directly, with Q unchanged.
- start with mode 000/001/110: no sequence. Treated as n=0, so DONE pulses and Q is unchanged.
- If start=1 and E=1 in the same cycle, start wins.
- RUN: each edge applies the latched mode once, sampling sin on that edge, and decrements count. On the edge where count goes 1 -> 0, move to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- busy=1 exactly while in RUN. It is registered and asserts the cycle after start.
- Inputs E, mode, D, n and start are ignored while in RUN and DONE.
- Saturation: n > WIDTH is clamped to WIDTH shifts. This applies to rotates too.
- Timing: a sequence of n>=1 shifts gives busy high for n cycles, then done high for 1 cycle. Total start-to-IDLE is n+2 edges.

Optional Feature:
- Macro UNIV_SHIFT_REGISTER_ABORT_EN.
- Defined:
  - Extra input port abort (1 bit).
  - abort=1 while in RUN forces IDLE at the next edge with no shift on that edge.
  - Q keeps its partial result, done does not pulse, and busy drops.
  - abort in IDLE or DONE is ignored.
- Undefined: no abort port; a sequence always runs to completion unless reset.

Test Plan (WIDTH=8):
- E=1 mode=001 D=8'hA5, then pull reset low asynchronously mid-cycle -> Q=8'h00, sout=0, busy=0 immediately, without waiting for a clock edge.
- E=1 mode=001 D=8'hA5 -> Q=8'hA5 after one edge. Then E=0 mode=001 D=8'hFF -> Q stays 8'hA5.
- Q=8'h81, E=1 mode=010 sin=0 -> Q=8'h02, sout=1.
- Q=8'h80, E=1 mode=111 -> Q=8'hC0, sout=0.
- Q=8'h81, start=1 mode=100 n=3 -> Q steps 8'h03, 8'h06, 8'h0C; busy high 3 cycles; done high the following cycle; E/mode changes during busy have no effect.
- Q=8'h00, start=1 mode=010 sin=1 n=12 -> exactly 8 shifts, Q=8'hFF, done pulses once. Then start=1 with n=0 -> done pulses next cycle, Q unchanged, busy never rises.
